// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
// The address/instruction width is fixed here (WIDTH) so the fetch entry struct
// and every block that carries it agree on one width.
package fetch_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_plus4(input logic [WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch sequencer (master)
// and the instruction memory (slave).
interface fetch_if;
  import fetch_pkg::*;

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries with push/pop/clear.
// Clear wins over push and pop; push while full is accepted only with a pop.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else if (clear) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; contents are only observed while the entry is counted valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) mem_r[wr_ptr_r] <= din;
  end

  fetch_buf_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .full  (full)
  );

endmodule

// File: rtl/fetch_chk.sv
// Assertion-only checkers for the fetch queues and the sequencer bookkeeping.
// They hold no state and drive nothing.
module fetch_buf_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic clear,
  input logic full
);
  // A push into a full queue without a same-cycle pop would lose an entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop && !clear));
endmodule

module fetch_sequencer_chk
  import fetch_pkg::*;
#(
  parameter int CW = 2
) (
  input logic             clk,
  input logic             rst,
  input fetch_state_e     state,
  input logic [CW-1:0]    tag_count,
  input logic [CW-1:0]    outstanding,
  input logic             tag_empty,
  input logic [WIDTH-1:0] tag_instr,
  input logic             rq_full
);
  // Outside a flush every outstanding request owns exactly one PC tag.
  a_tag_tracks: assert property (@(posedge clk) disable iff (!rst)
    (state == RUN) |-> (tag_count == outstanding));

  // Tag entries only carry a PC; the instruction half stays zero.
  a_tag_instr_zero: assert property (@(posedge clk) disable iff (!rst)
    !tag_empty |-> (tag_instr == '0));

  // A full response queue leaves no credit for any request in flight.
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
    !(rq_full && !tag_empty));
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, issues in-order imem requests under
// credit control, buffers responses with their PCs and presents the head entry
// to decode. A redirect flushes the queue and discards in-flight responses.
// Optional macro FETCH_PERF_EN adds saturating perf counters as extra outputs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int               BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  fetch_if.master          imem,
  output logic             InstrValidF,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCPlus4F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushes,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(BUF_DEPTH);

  fetch_state_e     state_r, state_n;
  logic [WIDTH-1:0] fetch_pc_r, fetch_pc_n;
  logic [CW-1:0]    outstanding_r, outstanding_n;
  logic [CW-1:0]    discard_r, discard_n;

  logic             req_s, hs_s, rsp_s, push_s, pop_s;
  logic [CW-1:0]    rq_count_s, tag_count_s;
  logic             rq_empty_s, rq_full_s, tag_empty_s, tag_full_s;
  fetch_entry_t     rq_head_s, rq_din_s, tag_head_s, tag_din_s;
  logic [CW:0]      inflight_s;

  // Credits cover both buffered entries and requests still in flight.
  assign inflight_s = {1'b0, rq_count_s} + {1'b0, outstanding_r};
  assign req_s      = (state_r == RUN) && !PCSrcE && (inflight_s < CREDITS);
  assign hs_s       = req_s && imem.imem_gnt;
  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rsp_s      = imem.imem_rvalid && (outstanding_r != CW'(0));
  assign push_s     = rsp_s && (discard_r == CW'(0)) && !PCSrcE;
  assign pop_s      = !rq_empty_s && !StallF && !PCSrcE;

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = fetch_pc_r;

  assign tag_din_s = '{pc: fetch_pc_r, instr: '0};
  assign rq_din_s  = '{pc: tag_head_s.pc, instr: imem.imem_rdata};

  // Next-state, next-PC and counter accounting; redirect dominates everything.
  always_comb begin
    state_n       = state_r;
    fetch_pc_n    = fetch_pc_r;
    discard_n     = discard_r;
    outstanding_n = outstanding_r + CW'(hs_s) - CW'(rsp_s);
    case (state_r)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (PCSrcE) begin
          fetch_pc_n = PCTargetE;
          discard_n  = outstanding_n;
          state_n    = (outstanding_n != CW'(0)) ? FLUSH : RUN;
        end else if (hs_s) begin
          fetch_pc_n = pc_plus4(fetch_pc_r);
        end else begin
          fetch_pc_n = fetch_pc_r;
        end
      end
      FLUSH: begin
        if (rsp_s && (discard_r != CW'(0))) begin
          discard_n = discard_r - CW'(1);
        end else begin
          discard_n = discard_r;
        end
        if (PCSrcE) begin
          fetch_pc_n = PCTargetE;
        end else begin
          fetch_pc_n = fetch_pc_r;
        end
        state_n = (discard_n == CW'(0)) ? RUN : FLUSH;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  // State, PC and credit counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= CW'(0);
      discard_r     <= CW'(0);
    end else begin
      state_r       <= state_n;
      fetch_pc_r    <= fetch_pc_n;
      outstanding_r <= outstanding_n;
      discard_r     <= discard_n;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_resp_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (PCSrcE),
    .din   (rq_din_s),
    .dout  (rq_head_s),
    .full  (rq_full_s),
    .empty (rq_empty_s),
    .count (rq_count_s)
  );

  // The tag queue pops only for accepted responses; discarded ones lost their tags at the flush.
  fetch_buf #(.DEPTH(BUF_DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (hs_s),
    .pop   (push_s),
    .clear (PCSrcE),
    .din   (tag_din_s),
    .dout  (tag_head_s),
    .full  (tag_full_s),
    .empty (tag_empty_s),
    .count (tag_count_s)
  );

  // Decode-facing view of the queue head; NOP and PC 0 when nothing is valid.
  always_comb begin
    InstrValidF = !rq_empty_s;
    if (!rq_empty_s) begin
      PCF    = rq_head_s.pc;
      InstrF = rq_head_s.instr;
    end else begin
      PCF    = '0;
      InstrF = NOP_INSTR;
    end
    PCPlus4F = pc_plus4(PCF);
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters: pops, redirect cycles, stalled valid cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched      <= 32'd0;
      perf_flushes      <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (pop_s && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (PCSrcE && (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
      if (!rq_empty_s && StallF && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  fetch_sequencer_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .state       (state_r),
    .tag_count   (tag_count_s),
    .outstanding (outstanding_r),
    .tag_empty   (tag_empty_s && !tag_full_s),
    .tag_instr   (tag_head_s.instr),
    .rq_full     (rq_full_s)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-configurable in-order imem model.
// Cycle c1 is the first cycle after the BOOT cycle that follows reset release.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        InstrValidF;
  logic [31:0] PCF, InstrF, PCPlus4F;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes, perf_stall_cycles;
`endif

  fetch_if bus ();

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem        (bus),
    .InstrValidF (InstrValidF),
    .PCF         (PCF),
    .InstrF      (InstrF),
    .PCPlus4F    (PCPlus4F)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_flushes      (perf_flushes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int checks = 0;
  int passes = 0;
  int lat = 1;
  int pcount = 0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a;
  endfunction

  // imem model: grant always, answer in order 'lat' cycles after the handshake.
  initial begin
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      pcount = pcount + 1;
      if (bus.imem_req && bus.imem_gnt) begin
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(pcount + lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= pcount + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= instr_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_rvalid <= 1'b0;
        bus.imem_rdata  <= 32'h0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Holds reset long enough for the model to drain; returns in the BOOT cycle.
  task automatic do_reset(input int l);
    rst = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; lat = l;
    repeat (8) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else passes++;
    checks++; if (InstrValidF !== 1'b0) $display("FAIL rst_valid got %b want 0", InstrValidF); else passes++;
    checks++; if (PCF !== 32'h0) $display("FAIL rst_pcf got %h want 0", PCF); else passes++;
    checks++; if (InstrF !== 32'h0000_0013) $display("FAIL rst_instr got %h want 00000013", InstrF); else passes++;
    checks++; if (PCPlus4F !== 32'h4) $display("FAIL rst_pcplus4 got %h want 4", PCPlus4F); else passes++;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int npops;
    do_reset(1);
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL boot_req got %b want 0", bus.imem_req); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL c1_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL c2_req got %b/%h want 1/4", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL c3_credit got %b want 0", bus.imem_req); else passes++;
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) $display("FAIL c3_head got %b/%h want 1/0", InstrValidF, PCF); else passes++;
    checks++; if (InstrF !== 32'hFFFF_FFFF || PCPlus4F !== 32'h4) $display("FAIL c3_instr got %h/%h want ffffffff/4", InstrF, PCPlus4F); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h4) $display("FAIL c4_head got %b/%h want 1/4", InstrValidF, PCF); else passes++;
    exp = 32'h8; npops = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (InstrValidF === 1'b1) begin
        checks++; if (PCF !== exp || InstrF !== instr_of(exp)) $display("FAIL stream_order got %h/%h want %h/%h", PCF, InstrF, exp, instr_of(exp)); else passes++;
        exp = exp + 32'd4; npops++;
      end
    end
    checks++; if (npops < 6) $display("FAIL stream_rate got %0d pops want >=6", npops); else passes++;
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    int npops;
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) $display("FAIL stall_start got %b/%h want 1/0", InstrValidF, PCF); else passes++;
    StallF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0 || bus.imem_req !== 1'b0) $display("FAIL stall_hold got %b/%h/%b want 1/0/0", InstrValidF, PCF, bus.imem_req); else passes++;
    end
    StallF = 1'b0;
    exp = 32'h0; npops = 0;
    for (int i = 0; i < 15; i++) begin
      if (InstrValidF === 1'b1) begin
        checks++; if (PCF !== exp || InstrF !== instr_of(exp)) $display("FAIL stall_resume got %h/%h want %h/%h", PCF, InstrF, exp, instr_of(exp)); else passes++;
        exp = exp + 32'd4; npops++;
      end
      @(negedge clk);
    end
    checks++; if (npops < 7) $display("FAIL stall_rate got %0d pops want >=7", npops); else passes++;
  endtask

  task automatic test_redirect();
    do_reset(3);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL rd_c1 got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) $display("FAIL rd_c2 got %b/%h want 1/4", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    #1;
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rd_c3_req got %b want 0", bus.imem_req); else passes++;
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (InstrValidF !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL rd_c4 got %b/%b want 0/0", InstrValidF, bus.imem_req); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL rd_c5 got %b/%b want 0/0", InstrValidF, bus.imem_req); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL rd_c6 got %b/%h want 1/100", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) $display("FAIL rd_c7 got %b/%h want 1/104", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0) $display("FAIL rd_c8 got %b want 0", InstrValidF); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0) $display("FAIL rd_c9 got %b want 0", InstrValidF); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h100 || InstrF !== instr_of(32'h100)) $display("FAIL rd_c10 got %b/%h/%h want 1/100/%h", InstrValidF, PCF, InstrF, instr_of(32'h100)); else passes++;
  endtask

  task automatic test_redirect_pop();
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) $display("FAIL rp_head got %b/%h want 1/0", InstrValidF, PCF); else passes++;
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    #1;
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rp_req got %b want 0", bus.imem_req); else passes++;
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (InstrValidF !== 1'b0 || InstrF !== 32'h0000_0013) $display("FAIL rp_empty got %b/%h want 0/00000013", InstrValidF, InstrF); else passes++;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) $display("FAIL rp_newreq got %b/%h want 1/200", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b0 || bus.imem_addr !== 32'h204) $display("FAIL rp_c5 got %b/%h want 0/204", InstrValidF, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h200 || InstrF !== instr_of(32'h200)) $display("FAIL rp_c6 got %b/%h/%h want 1/200/%h", InstrValidF, PCF, InstrF, instr_of(32'h200)); else passes++;
  endtask

  task automatic test_wrap();
    do_reset(1);
    @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL wr_c1 got %b want 0", bus.imem_req); else passes++;
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_c2 got %b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL wr_c3 got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || InstrF !== 32'h3) $display("FAIL wr_c4 got %b/%h/%h/%h want 1/fffffffc/0/3", InstrValidF, PCF, PCPlus4F, InstrF); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0 || PCPlus4F !== 32'h4) $display("FAIL wr_c5 got %b/%h/%h want 1/0/4", InstrValidF, PCF, PCPlus4F); else passes++;
  endtask

  task automatic test_reset_flush();
    do_reset(3);
    repeat (3) @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    @(negedge clk);
    PCSrcE = 1'b0;
`ifdef FETCH_PERF_EN
    checks++; if (perf_flushes !== 32'd1) $display("FAIL perf_flush got %0d want 1", perf_flushes); else passes++;
`endif
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || InstrValidF !== 1'b0) $display("FAIL rf_ctrl got %b/%b want 0/0", bus.imem_req, InstrValidF); else passes++;
    checks++; if (PCF !== 32'h0 || InstrF !== 32'h0000_0013 || PCPlus4F !== 32'h4) $display("FAIL rf_data got %h/%h/%h want 0/00000013/4", PCF, InstrF, PCPlus4F); else passes++;
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0 || perf_stall_cycles !== 32'd0) $display("FAIL rf_perf got %0d/%0d/%0d want 0/0/0", perf_fetched, perf_flushes, perf_stall_cycles); else passes++;
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rf_boot got %b want 0", bus.imem_req); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) $display("FAIL rf_c1 got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h4) $display("FAIL rf_c2 got %h want 4", bus.imem_addr); else passes++;
    repeat (2) @(negedge clk);
    checks++; if (InstrValidF !== 1'b0) $display("FAIL rf_late got %b want 0", InstrValidF); else passes++;
    @(negedge clk);
    checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0 || InstrF !== 32'hFFFF_FFFF) $display("FAIL rf_c5 got %b/%h/%h want 1/0/ffffffff", InstrValidF, PCF, InstrF); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_flush();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
